// File: rtl/mmio_dma_ctrl_pkg.sv
// mmio_dma_ctrl_pkg: register map, FSM state type and STATUS bit positions for the DMA control block
package mmio_dma_ctrl_pkg;

    localparam logic [15:0] REG_GO      = 16'h0050;
    localparam logic [15:0] REG_RD_ADDR = 16'h0052;
    localparam logic [15:0] REG_WR_ADDR = 16'h0054;
    localparam logic [15:0] REG_SIZE    = 16'h0056;
    localparam logic [15:0] REG_DONE    = 16'h0058;
    localparam logic [15:0] REG_STATUS  = 16'h005A;
    localparam logic [15:0] REG_CYCLES  = 16'h005C;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_ERR  = 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

endpackage

// File: rtl/mmio_dma_ctrl_if.sv
// mmio_dma_ctrl_if: MMIO bus with independent read and write channels so both can fire in one cycle
interface mmio_dma_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport user (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );

    modport host (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

endinterface

// File: rtl/mmio_dma_ctrl.sv
// mmio_dma_ctrl: MMIO register file, transfer sequencer and busy-cycle counter for one DMA engine
module mmio_dma_ctrl
    import mmio_dma_ctrl_pkg::*;
#(
    parameter int MMIO_DATA_WIDTH = 64,
    parameter int MMIO_ADDR_WIDTH = 16,
    parameter int ADDR_WIDTH      = 64,
    parameter int SIZE_WIDTH      = 32,
    parameter int CNT_WIDTH       = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mmio_dma_ctrl_if.user         mmio,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [SIZE_WIDTH-1:0] dma_size,
    output logic                  dma_go,
    input  logic                  dma_done,
    output logic                  busy
);

    state_t                     state;
    logic                       done_flag;
    logic                       err;
    logic [CNT_WIDTH-1:0]       cycles;
    logic [1:0]                 status;
    logic [MMIO_DATA_WIDTH-1:0] rd_mux;
    logic                       go_wr;

    assign go_wr = mmio.wr_en && mmio.wr_addr == MMIO_ADDR_WIDTH'(REG_GO);

    // Transfer config; frozen while busy so the engine sees stable values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rd_addr <= '0;
            dma_wr_addr <= '0;
            dma_size    <= '0;
        end else if (mmio.wr_en && !busy) begin
            if (mmio.wr_addr == MMIO_ADDR_WIDTH'(REG_RD_ADDR)) dma_rd_addr <= ADDR_WIDTH'(mmio.wr_data);
            if (mmio.wr_addr == MMIO_ADDR_WIDTH'(REG_WR_ADDR)) dma_wr_addr <= ADDR_WIDTH'(mmio.wr_data);
            if (mmio.wr_addr == MMIO_ADDR_WIDTH'(REG_SIZE))    dma_size    <= SIZE_WIDTH'(mmio.wr_data);
        end
    end

    // Sequencer: accepts GO, pulses the engine, counts busy cycles and latches completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dma_go    <= 1'b0;
            busy      <= 1'b0;
            done_flag <= 1'b0;
            err       <= 1'b0;
            cycles    <= '0;
        end else begin
            dma_go <= 1'b0;
            case (state)
                IDLE: if (go_wr) begin
                    cycles    <= '0;
                    err       <= 1'b0;
                    done_flag <= dma_size == '0;
                    busy      <= dma_size != '0;
                    dma_go    <= dma_size != '0;
                    state     <= dma_size != '0 ? START : DONE;
                end
                START: begin
                    if (go_wr) err <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (go_wr) err <= 1'b1;
                    cycles <= cycles + CNT_WIDTH'(!(&cycles));
                    if (dma_done) begin
                        busy      <= 1'b0;
                        done_flag <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    // Read-side decode of the register map; unmapped and write-only addresses read as zero
    always_comb begin
        status              = '0;
        status[STATUS_BUSY] = busy;
        status[STATUS_ERR]  = err;
        rd_mux              = '0;
        case (mmio.rd_addr)
            MMIO_ADDR_WIDTH'(REG_RD_ADDR): rd_mux = MMIO_DATA_WIDTH'(dma_rd_addr);
            MMIO_ADDR_WIDTH'(REG_WR_ADDR): rd_mux = MMIO_DATA_WIDTH'(dma_wr_addr);
            MMIO_ADDR_WIDTH'(REG_SIZE):    rd_mux = MMIO_DATA_WIDTH'(dma_size);
            MMIO_ADDR_WIDTH'(REG_DONE):    rd_mux = MMIO_DATA_WIDTH'(done_flag);
            MMIO_ADDR_WIDTH'(REG_STATUS):  rd_mux = MMIO_DATA_WIDTH'(status);
            MMIO_ADDR_WIDTH'(REG_CYCLES):  rd_mux = MMIO_DATA_WIDTH'(cycles);
            default:                       rd_mux = '0;
        endcase
    end

    // Registered read data, held until the next read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mmio.rd_data <= '0;
        else if (mmio.rd_en) mmio.rd_data <= rd_mux;
    end

endmodule

// File: tb/tb_mmio_dma_ctrl.sv
// tb_mmio_dma_ctrl: directed and randomized transfers checked against a register-level reference model
module tb_mmio_dma_ctrl;
    import mmio_dma_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] dma_rd_addr;
    logic [63:0] dma_wr_addr;
    logic [31:0] dma_size;
    logic        dma_go;
    logic        dma_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int go_count = 0;

    logic [63:0] m_rd, m_wr, m_cycles;
    logic [31:0] m_size;
    logic        m_done, m_err;

    mmio_dma_ctrl_if #(.ADDR_W(16), .DATA_W(64)) mmio ();

    mmio_dma_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mmio        (mmio),
        .dma_rd_addr (dma_rd_addr),
        .dma_wr_addr (dma_wr_addr),
        .dma_size    (dma_size),
        .dma_go      (dma_go),
        .dma_done    (dma_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dma_go) go_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [15:0] a);
        case (a)
            REG_RD_ADDR: return m_rd;
            REG_WR_ADDR: return m_wr;
            REG_SIZE:    return {32'h0, m_size};
            REG_DONE:    return {63'h0, m_done};
            REG_STATUS:  return {62'h0, m_err, 1'b0};
            REG_CYCLES:  return m_cycles;
            default:     return 64'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_size = 0; m_done = 0; m_err = 0; m_cycles = 0;
    endtask

    task automatic mmio_write(input logic [15:0] a, input logic [63:0] d);
        mmio.wr_en = 1'b1; mmio.wr_addr = a; mmio.wr_data = d;
        @(posedge clk); #1;
        mmio.wr_en = 1'b0;
    endtask

    task automatic mmio_read(input logic [15:0] a, output logic [63:0] d);
        mmio.rd_en = 1'b1; mmio.rd_addr = a;
        @(posedge clk); #1;
        mmio.rd_en = 1'b0;
        d = mmio.rd_data;
    endtask

    task automatic cfg_write(input logic [15:0] a, input logic [63:0] d);
        mmio_write(a, d);
        if (a == REG_RD_ADDR) m_rd = d;
        if (a == REG_WR_ADDR) m_wr = d;
        if (a == REG_SIZE) m_size = d[31:0];
    endtask

    task automatic check_all(input string tag);
        logic [63:0] v;
        for (int a = 'h50; a <= 'h60; a += 2) begin
            mmio_read(16'(a), v);
            check($sformatf("%s_reg%0h", tag, a), v, model_read(16'(a)));
        end
    endtask

    // GO then emulate the engine: dma_done rises d cycles after the dma_go cycle
    task automatic run_transfer(input int d, input bit inject);
        int g0;
        logic [63:0] v;
        g0 = go_count;
        mmio_write(REG_GO, 64'h0);
        m_err = 1'b0;
        m_cycles = 0;
        if (m_size == 0) begin
            m_done = 1'b1;
            check("zero_go", dma_go, 0);
            check("zero_busy", busy, 0);
            mmio_read(REG_DONE, v);
            check("zero_done", v, 1);
            check("zero_go_count", go_count - g0, 0);
            return;
        end
        m_done = 1'b0;
        check("go_high", dma_go, 1);
        check("busy_high", busy, 1);
        check("out_rd_addr", dma_rd_addr, m_rd);
        check("out_wr_addr", dma_wr_addr, m_wr);
        check("out_size", dma_size, 64'(m_size));
        for (int k = 1; k <= d; k++) begin
            @(posedge clk); #1;
            mmio.wr_en = 1'b0;
            mmio.rd_en = 1'b0;
            if (k == 1) check("go_one_cycle", dma_go, 0);
            if (inject) begin
                if (k == 1) begin
                    mmio.wr_en = 1'b1; mmio.wr_addr = REG_GO; mmio.wr_data = 64'h1;
                    m_err = 1'b1;
                end
                if (k == 2) begin
                    mmio.wr_en = 1'b1; mmio.wr_addr = REG_RD_ADDR; mmio.wr_data = 64'hDEAD;
                end
                if (k == 3) begin
                    mmio.rd_en = 1'b1; mmio.rd_addr = REG_STATUS;
                end
                if (k == 4) check("status_busy_err", mmio.rd_data, 64'h3);
            end
            if (k == d) begin
                check("busy_wait", busy, 1);
                dma_done = 1'b1;
            end
        end
        @(posedge clk); #1;
        dma_done = 1'b0;
        m_done = 1'b1;
        m_cycles = 64'(d);
        check("busy_fall", busy, 0);
        check("go_count", go_count - g0, 1);
    endtask

    initial begin
        logic [63:0] v;
        int d;
        bit inj;
        rst_n = 1'b0;
        dma_done = 1'b0;
        mmio.rd_en = 1'b0; mmio.rd_addr = '0;
        mmio.wr_en = 1'b0; mmio.wr_addr = '0; mmio.wr_data = '0;
        model_reset();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_go", dma_go, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_data", mmio.rd_data, 0);
        check_all("rst");

        mmio_write(16'h0060, 64'hFFFF);
        cfg_write(REG_RD_ADDR, 64'h1000);
        cfg_write(REG_WR_ADDR, 64'h2000);
        cfg_write(REG_SIZE, 64'h4);
        check_all("cfg");
        run_transfer(10, 1'b1);
        check_all("basic");

        cfg_write(REG_SIZE, 64'h0);
        run_transfer(0, 1'b0);
        check_all("zero");

        cfg_write(REG_SIZE, 64'h4);
        mmio.wr_en = 1'b1; mmio.wr_addr = REG_SIZE; mmio.wr_data = 64'h8;
        mmio.rd_en = 1'b1; mmio.rd_addr = REG_SIZE;
        @(posedge clk); #1;
        mmio.wr_en = 1'b0; mmio.rd_en = 1'b0;
        m_size = 32'h8;
        check("rw_same_cycle", mmio.rd_data, 64'h4);
        check("rd_data_hold", mmio.rd_data, 64'h4);
        mmio_read(REG_SIZE, v);
        check("rw_after", v, 64'h8);

        for (int i = 0; i < 20; i++) begin
            cfg_write(REG_RD_ADDR, {$urandom, $urandom});
            cfg_write(REG_WR_ADDR, {$urandom, $urandom});
            cfg_write(REG_SIZE, $urandom_range(0, 3) == 0 ? 64'hABCD_0000_0000 :
                                {$urandom, 32'($urandom_range(1, 255))});
            d = $urandom_range(1, 16);
            inj = d >= 5 && $urandom_range(0, 1) == 1;
            run_transfer(d, inj);
            check_all($sformatf("rnd%0d", i));
        end

        cfg_write(REG_RD_ADDR, 64'h3000);
        cfg_write(REG_SIZE, 64'h2);
        d = go_count;
        mmio_write(REG_GO, 64'h0);
        check("pre_rst_go", dma_go, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_go", dma_go, 0);
        check("async_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check("rst_go_count", go_count - d, 0);
        check_all("midrst");
        cfg_write(REG_RD_ADDR, 64'h1000);
        cfg_write(REG_WR_ADDR, 64'h2000);
        cfg_write(REG_SIZE, 64'h4);
        run_transfer(7, 1'b0);
        check_all("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
